// File: rtl/pipe_mux_skid_pkg.sv
// pipe_mux_skid_pkg: shared defaults and select-width check for pipe_mux_skid
package pipe_mux_skid_pkg;
  localparam int DEF_WIDTH = 32;
  function automatic bit sel_w_ok(input int n, input int sel_w);
    return sel_w >= $clog2(n);
  endfunction
endpackage

// File: rtl/pipe_mux_skid_mux_n_sel.sv
// mux_n_sel: combinational N:1 word select with out-of-range detection
module mux_n_sel
  import pipe_mux_skid_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N*WIDTH-1:0] x_flat,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   word,
  output logic               bad
);
  always_comb begin
    word = '0;
    bad  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        word = x_flat[k*WIDTH +: WIDTH];
        bad  = 1'b0;
      end
    end
  end
endmodule

// File: rtl/pipe_mux_skid.sv
// pipe_mux_skid: N:1 operand select with registered output and 2-entry skid buffer
module pipe_mux_skid
  import pipe_mux_skid_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] x_flat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_bad
);
  if (!sel_w_ok(N, SEL_W)) begin : g_sel_w_err
    $error("pipe_mux_skid: SEL_W too small for N");
  end
  logic [WIDTH-1:0] word;
  logic             bad;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] skid_sel;
  logic             skid_bad;
  logic             accept;
  logic             main_free;
  mux_n_sel #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) u_mux (
    .x_flat(x_flat),
    .sel   (sel),
    .word  (word),
    .bad   (bad)
  );
  assign in_ready  = !skid_valid && !rst;
  assign accept    = in_valid && in_ready && !flush;
  assign main_free = !out_valid || out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      out_bad    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_sel   <= '0;
      skid_bad   <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      out_valid <= skid_valid || accept;
      if (skid_valid) begin
        {out_data, out_sel, out_bad} <= {skid_data, skid_sel, skid_bad};
        skid_valid <= 1'b0;
      end else if (accept) begin
        {out_data, out_sel, out_bad} <= {word, sel, bad};
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      {skid_data, skid_sel, skid_bad} <= {word, sel, bad};
    end
  end
endmodule
